fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch and execution sequencer that drives the multi-cycle `Decode` unit. It reads the instruction at the current PC from instruction memory and hands it to `Decode` with `run`. It waits for `ok`, then retires the instruction by advancing PC by 4 or loading the branch/jump target that `Decode` reported on `PC_wren`/`PC_wdata`. It also provides start/halt/single-step control, an instruction counter, and a watchdog for an unresponsive `Decode`.

## Interface
- `RESET_PC`, default 19'h0: byte address loaded into PC on reset.
- `FETCH_LAT`, default 1: instruction memory read latency in cycles (≥1).
- `TIMEOUT`, default 64: maximum cycles in EXEC without `ok` before a fault (≥2).
- `clk` in 1: the only clock; all logic updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: level-sampled; leaves IDLE or HALT.
- `halt_req` in 1: request a stop at the next instruction boundary.
- `IMem_raddr` out 17: instruction word address, always equal to PC[18:2].
- `IMem_rdata` in 32: instruction word, valid `FETCH_LAT` cycles after the address is presented.
- `instr` out 32: instruction presented to `Decode`.
- `PC` out 19: byte address of the current instruction.
- `run` out 1: execute request to `Decode`.
- `ok` in 1: `Decode` completion.
- `PC_wdata` in 32: branch/jump target from `Decode`.
- `PC_wren` in 1: branch/jump taken strobe from `Decode`.
- `retire` out 1: one-cycle pulse per completed instruction.
- `halted` out 1: high in HALT.
- `fault` out 1: high in FAULT.
- `instr_count` out 32: number of retired instructions; wraps.

## Operation
- States: IDLE, FETCH, EXEC, RETIRE, HALT, FAULT. Reset state is IDLE.
- IDLE: if `start` is high, go to FETCH. `halt_req` is ignored in this state.
- FETCH: a latency counter runs for `FETCH_LAT` cycles. In the last cycle the block captures `instr` <= `IMem_rdata`, sets `run` <= 1, clears `br_pend` and the watchdog, and goes to EXEC.
- EXEC, with `run` held high:
  - When `PC_wren` is sampled high, set `br_pend` <= 1 and `br_tgt` <= {`PC_wdata`[18:2], 2'b00}. `PC_wdata` bits 31:19 and 1:0 are ignored.
  - When `ok` is sampled high, go to RETIRE. If `PC_wren` and `ok` are high in the same cycle, the branch is taken.
  - The watchdog increments every EXEC cycle. When it reaches `TIMEOUT` with no `ok`, set `run` <= 0 and go to FAULT.
- RETIRE:
  - `run` is already 0, dropped on the `ok` edge so `Decode` clears `ok`.
  - PC <= `br_pend` ? `br_tgt` : PC + 4. The addition is 19-bit modulo, so 19'h7FFFC + 4 = 0.
  - `retire` = 1 and `instr_count` increments.
  - Next state is HALT if `halt_pend` is set; `halt_pend` is cleared on that transition. Otherwise the next state is FETCH.
- `halt_pend` is set whenever `halt_req` is sampled high outside IDLE and FAULT. It is sticky until it is consumed in RETIRE.
- HALT: `halted` = 1. `start` goes to FETCH and resumes at the current PC. If `start` and `halt_req` are high in the same cycle, exactly one instruction executes and the block returns to HALT (single-step).
- FAULT: `fault` = 1, `run` = 0, PC frozen on the faulting instruction. The only exit is `rst_n`.
- Registers `ok`, `PC_wren` and `IMem_rdata` are never used outside the states listed above.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - PC = `RESET_PC`, `IMem_raddr` = `RESET_PC`[18:2].
  - `instr` = 0, `run` = 0, `retire` = 0, `halted` = 0, `fault` = 0, `instr_count` = 0.
  - Internal `br_pend`, `halt_pend` and counters are 0.
- Reset during EXEC drops `run` at once; `Decode` returns to its idle state on its next clock.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` sampled at edge t means FETCH during cycles t+1 … t+`FETCH_LAT`, and `run` is high from edge t+`FETCH_LAT`.
- The cycle after `ok` is sampled: `run` = 0 and `retire` = 1. The new PC is visible in the same cycle as `retire`.
- Per-instruction overhead outside `Decode` is `FETCH_LAT` + 1 cycles, so back-to-back instructions issue every `FETCH_LAT` + 1 + (Decode cycles) cycles.
- `run` is never high in the cycle after `ok` is sampled high, which guarantees `Decode` sees `run && ok` and clears `ok`.

## Test plan
- Straight-line execution:
  - Stimulus: reset, `start` = 1, `Decode` model returns `ok` 5 cycles after `run`, 3 instructions.
  - Required: PC goes 0→4→8→12, three `retire` pulses, `instr_count` = 3, `instr` matches memory at word addresses 0, 1, 2.
- Jump:
  - Stimulus: `PC_wren` pulses with `PC_wdata` = 32'h0000_0103 one cycle before `ok`.
  - Required: next PC = 19'h100, `IMem_raddr` = 17'h40. A following instruction without `PC_wren` advances PC to 19'h104.
- Halt and single-step:
  - Stimulus: `halt_req` pulsed mid-EXEC.
  - Required: the current instruction retires, then `halted` = 1 with PC = next address. Then `start` and `halt_req` together: exactly one `retire`, then `halted` = 1 again.
- Watchdog:
  - Stimulus: `Decode` model never asserts `ok`, `TIMEOUT` = 8.
  - Required: `run` falls 8 cycles after rising, `fault` = 1, PC unchanged, `start` ignored until `rst_n` low.
- PC wrap and latency:
  - Stimulus: `RESET_PC` = 19'h7FFFC, `FETCH_LAT` = 3.
  - Required: `run` rises 3 cycles after `start` is sampled, PC wraps to 0 after `retire`.
- Reset mid-EXEC:
  - Stimulus: assert `rst_n` low while `run` = 1.
  - Required: `run` = 0 immediately, all outputs at reset values, restart fetches from `RESET_PC`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions, hands them to Decode with run/ok, retires and advances PC.
// Adds start/halt/single-step control, a retire counter and an EXEC watchdog.
module fetch_sequencer #(
  parameter logic [18:0] RESET_PC  = 19'h0,
  parameter int          FETCH_LAT = 1,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  output logic [16:0] IMem_raddr,
  input  logic [31:0] IMem_rdata,
  output logic [31:0] instr,
  output logic [18:0] PC,
  output logic        run,
  input  logic        ok,
  input  logic [31:0] PC_wdata,
  input  logic        PC_wren,
  output logic        retire,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);
  localparam int LW = $clog2(FETCH_LAT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, RETIRE, HALT, FAULT} state_t;
  state_t state, next;
  logic [LW-1:0] lat;
  logic [WW-1:0] wd;
  logic br_pend, halt_pend;
  logic [18:0] br_tgt, jmp_tgt;
  logic fetch_done, timeout, unused_bits;
  assign IMem_raddr = PC[18:2];
  assign jmp_tgt = {PC_wdata[18:2], 2'b00};
  assign fetch_done = lat == LW'(FETCH_LAT - 1);
  assign timeout = wd == WW'(TIMEOUT - 1);
  assign unused_bits = ^{PC_wdata[31:19], PC_wdata[1:0]};
  always_comb begin
    next = state;
    case (state)
      IDLE, HALT: next = start ? FETCH : state;
      FETCH:      next = fetch_done ? EXEC : FETCH;
      EXEC:       next = ok ? RETIRE : timeout ? FAULT : EXEC;
      RETIRE:     next = halt_pend ? HALT : FETCH;
      default:    next = FAULT;
    endcase
  end
  // Outputs are registered from next-state so run drops on the same edge ok is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat         <= '0;
      wd          <= '0;
      PC          <= RESET_PC;
      instr       <= '0;
      run         <= 1'b0;
      retire      <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
      br_pend     <= 1'b0;
      br_tgt      <= '0;
      halt_pend   <= 1'b0;
    end else begin
      state     <= next;
      lat       <= (state == FETCH && !fetch_done) ? lat + 1'b1 : '0;
      wd        <= (state == EXEC && next == EXEC) ? wd + 1'b1 : '0;
      run       <= next == EXEC;
      retire    <= next == RETIRE;
      halted    <= next == HALT;
      fault     <= next == FAULT;
      halt_pend <= (halt_pend && state != RETIRE) || (halt_req && state != IDLE && state != FAULT);
      if (state == FETCH && fetch_done) begin
        instr   <= IMem_rdata;
        br_pend <= 1'b0;
      end
      if (state == EXEC && PC_wren) begin
        br_pend <= 1'b1;
        br_tgt  <= jmp_tgt;
      end
      if (state == EXEC && ok) begin
        PC          <= PC_wren ? jmp_tgt : br_pend ? br_tgt : PC + 19'd4;
        instr_count <= instr_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch/exec/retire, jumps, halt/step, watchdog, wrap and reset.
module tb_fetch_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start, halt_req, ok, pc_wren, run, retire, halted, fault;
  logic [31:0] pc_wdata, rdata, instr, count;
  logic [16:0] raddr;
  logic [18:0] pc;
  logic start_b, halt_req_b, ok_b, pc_wren_b, run_b, retire_b, halted_b, fault_b;
  logic [31:0] pc_wdata_b, rdata_b, instr_b, count_b, p1, p2;
  logic [16:0] raddr_b;
  logic [18:0] pc_b;

  fetch_sequencer #(.RESET_PC(19'h0), .FETCH_LAT(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .IMem_raddr(raddr), .IMem_rdata(rdata), .instr(instr), .PC(pc), .run(run),
    .ok(ok), .PC_wdata(pc_wdata), .PC_wren(pc_wren), .retire(retire),
    .halted(halted), .fault(fault), .instr_count(count));

  fetch_sequencer #(.RESET_PC(19'h7FFFC), .FETCH_LAT(3), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .halt_req(halt_req_b),
    .IMem_raddr(raddr_b), .IMem_rdata(rdata_b), .instr(instr_b), .PC(pc_b), .run(run_b),
    .ok(ok_b), .PC_wdata(pc_wdata_b), .PC_wren(pc_wren_b), .retire(retire_b),
    .halted(halted_b), .fault(fault_b), .instr_count(count_b));

  // Instruction memories: word = C0DE_0000 | word address, 1- and 3-cycle read latency.
  always @(posedge clk) rdata <= 32'hC0DE_0000 | {15'h0, raddr};
  always @(posedge clk) begin
    p1 <= 32'hC0DE_0000 | {15'h0, raddr_b};
    p2 <= p1;
    rdata_b <= p2;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          jmp;
    logic [31:0] tgt;
    bit          hreq;
    logic [18:0] pc;
    logic [31:0] ins;
  } vec_t;
  vec_t vecs[7];

  // Acts as Decode: ok sampled 5 edges after run rises, jump/halt strobe one edge earlier.
  task automatic run_instr(input vec_t v);
    int n = 0;
    while (!run && n < 20) begin
      step();
      n++;
    end
    chk("run_rise", {31'h0, run}, 1);
    chk("instr", instr, v.ins);
    repeat (3) step();
    pc_wren = v.jmp;
    pc_wdata = v.tgt;
    halt_req = v.hreq;
    step();
    chk("run_held", {31'h0, run}, 1);
    pc_wren = 1'b0;
    halt_req = 1'b0;
    ok = 1'b1;
    step();
    ok = 1'b0;
    chk("run_drop", {31'h0, run}, 0);
    chk("retire", {31'h0, retire}, 1);
    chk("pc", {13'h0, pc}, {13'h0, v.pc});
    chk("raddr", {15'h0, raddr}, {15'h0, v.pc[18:2]});
  endtask

  initial begin
    int n;
    vecs[0] = '{0, 32'h0, 0, 19'h4, 32'hC0DE_0000};
    vecs[1] = '{0, 32'h0, 0, 19'h8, 32'hC0DE_0001};
    vecs[2] = '{0, 32'h0, 0, 19'hC, 32'hC0DE_0002};
    vecs[3] = '{1, 32'h0000_0103, 0, 19'h100, 32'hC0DE_0003};
    vecs[4] = '{0, 32'h0, 0, 19'h104, 32'hC0DE_0040};
    vecs[5] = '{1, 32'hFFF8_0207, 0, 19'h204, 32'hC0DE_0041};
    vecs[6] = '{0, 32'h0, 1, 19'h208, 32'hC0DE_0081};
    {start, halt_req, ok, pc_wren, pc_wdata} = '0;
    {start_b, halt_req_b, ok_b, pc_wren_b, pc_wdata_b} = '0;
    repeat (2) step();
    chk("rst_pc", {13'h0, pc}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_flags", {27'h0, run, retire, halted, fault, 1'b0}, 0);
    chk("rst_count", count, 0);
    chk("rst_pc_b", {13'h0, pc_b}, 32'h7FFFC);
    chk("rst_raddr_b", {15'h0, raddr_b}, 32'h1FFFF);
    rst_n = 1'b1;
    step();

    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    while (!run_b && n < 20) begin
      step();
      n++;
    end
    chk("b_latency", n, 3);
    chk("b_instr", instr_b, 32'hC0DF_FFFF);
    step();
    ok_b = 1'b1;
    step();
    ok_b = 1'b0;
    chk("b_run_drop", {31'h0, run_b}, 0);
    chk("b_retire", {31'h0, retire_b}, 1);
    chk("b_pc_wrap", {13'h0, pc_b}, 0);
    chk("b_count", count_b, 1);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_instr(vecs[i]);
      chk("count", count, i + 1);
    end
    step();
    chk("halted", {31'h0, halted}, 1);
    chk("retire_pulse", {31'h0, retire}, 0);
    chk("halt_pc", {13'h0, pc}, 32'h208);
    repeat (3) step();
    chk("halt_stays", {30'h0, halted, run}, 2);

    start = 1'b1;
    halt_req = 1'b1;
    step();
    start = 1'b0;
    halt_req = 1'b0;
    run_instr('{0, 32'h0, 0, 19'h20C, 32'hC0DE_0082});
    chk("step_count", count, 8);
    step();
    chk("step_halted", {31'h0, halted}, 1);
    repeat (4) step();
    chk("step_once", count, 8);
    chk("step_idle", {30'h0, halted, run}, 2);

    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!run && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (run && n < 20) begin
      step();
      n++;
    end
    chk("wd_cycles", n, 8);
    chk("wd_fault", {30'h0, fault, halted}, 2);
    chk("wd_pc", {13'h0, pc}, 32'h20C);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    chk("fault_sticky", {30'h0, fault, run}, 2);
    chk("fault_pc", {13'h0, pc}, 32'h20C);
    chk("fault_count", count, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {27'h0, fault, run, retire, halted, 1'b0}, 0);
    chk("async_rst_pc", {13'h0, pc}, 0);
    step();
    rst_n = 1'b1;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!run && n < 20) begin
      step();
      n++;
    end
    chk("exec_run", {31'h0, run}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_run", {31'h0, run}, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_pc", {13'h0, pc}, 0);
    chk("mid_rst_count", count, 0);
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(vecs[0]);
    chk("restart_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
